// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : decode_stage
//  Description : One-entry decode pipeline register with field/flag decode,
//                load-use hazard stall and a saturating stall counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module decode_stage #(
    parameter int INSTR_W  = 19,
    parameter int OPC_W    = 5,
    parameter int REG_W    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [INSTR_W-1:0]               in_instr,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             flush,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [OPC_W-1:0]                 opcode,
    output logic [REG_W-1:0]                 r1,
    output logic [REG_W-1:0]                 r2,
    output logic [REG_W-1:0]                 r3,
    output logic [INSTR_W-OPC_W-3*REG_W-1:0] imm,
    output logic                             is_load,
    output logic                             is_store,
    output logic                             is_mem_access,
    output logic                             is_branch,
    output logic                             is_jump,
    output logic [15:0]                      stall_cnt
);

    localparam int IMM_W = INSTR_W - OPC_W - 3*REG_W;

    localparam logic [OPC_W-1:0] c_opc_load  = OPC_W'(5'b01011);
    localparam logic [OPC_W-1:0] c_opc_store = OPC_W'(5'b01100);
    localparam logic [OPC_W-1:0] c_opc_jump  = OPC_W'(5'b11000);
    localparam logic [2:0]       c_br_top    = 3'b101;
    localparam logic [2:0]       c_load_lat  = 3'(LOAD_LAT);
    localparam logic [15:0]      c_stall_max = 16'hFFFF;

    // Field split of the incoming word
    logic [OPC_W-1:0] w_opc;
    logic [REG_W-1:0] w_r1;
    logic [REG_W-1:0] w_r2;
    logic [REG_W-1:0] w_r3;
    logic [IMM_W-1:0] w_imm;

    assign w_opc = in_instr[INSTR_W-1 -: OPC_W];
    assign w_r1  = in_instr[INSTR_W-OPC_W-1 -: REG_W];
    assign w_r2  = in_instr[INSTR_W-OPC_W-REG_W-1 -: REG_W];
    assign w_r3  = in_instr[INSTR_W-OPC_W-2*REG_W-1 -: REG_W];
    assign w_imm = in_instr[IMM_W-1:0];

    logic w_dec_load;
    logic w_dec_store;
    logic w_dec_branch;
    logic w_dec_jump;

    assign w_dec_load   = (w_opc == c_opc_load);
    assign w_dec_store  = (w_opc == c_opc_store);
    assign w_dec_branch = (w_opc[OPC_W-1 -: 3] == c_br_top);
    assign w_dec_jump   = (w_opc == c_opc_jump);

    logic             r_out_valid;
    logic [OPC_W-1:0] r_opcode;
    logic [REG_W-1:0] r_r1;
    logic [REG_W-1:0] r_r2;
    logic [REG_W-1:0] r_r3;
    logic [IMM_W-1:0] r_imm;
    logic             r_is_load;
    logic             r_is_store;
    logic             r_is_branch;
    logic             r_is_jump;
    logic [REG_W-1:0] r_ld_dst;
    logic [2:0]       r_ld_cnt;
    logic [15:0]      r_stall_cnt;

    logic w_hazard;
    logic w_in_ready;
    logic w_accept;
    logic w_handoff;

    // Hazard looks at the incoming word, not the held one
    assign w_hazard   = (r_ld_cnt != 3'd0) && in_valid &&
                        ((w_r2 == r_ld_dst) || (w_r3 == r_ld_dst));
    assign w_in_ready = (!r_out_valid || out_ready) && !w_hazard && !flush;
    assign w_accept   = in_valid && w_in_ready;
    assign w_handoff  = r_out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_opcode    <= '0;
            r_r1        <= '0;
            r_r2        <= '0;
            r_r3        <= '0;
            r_imm       <= '0;
            r_is_load   <= 1'b0;
            r_is_store  <= 1'b0;
            r_is_branch <= 1'b0;
            r_is_jump   <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_opcode    <= w_opc;
            r_r1        <= w_r1;
            r_r2        <= w_r2;
            r_r3        <= w_r3;
            r_imm       <= w_imm;
            r_is_load   <= w_dec_load;
            r_is_store  <= w_dec_store;
            r_is_branch <= w_dec_branch;
            r_is_jump   <= w_dec_jump;
        end else if (w_handoff) begin
            r_out_valid <= 1'b0;
        end
    end

    // A load leaving the stage rearms the tracker, overriding the countdown
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_dst <= '0;
            r_ld_cnt <= 3'd0;
        end else if (flush) begin
            r_ld_cnt <= 3'd0;
        end else if (w_handoff && r_is_load) begin
            r_ld_dst <= r_r1;
            r_ld_cnt <= c_load_lat;
        end else if (r_ld_cnt != 3'd0) begin
            r_ld_cnt <= r_ld_cnt - 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= 16'd0;
        end else if (!flush && w_hazard && (r_stall_cnt != c_stall_max)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign in_ready      = w_in_ready;
    assign out_valid     = r_out_valid;
    assign opcode        = r_opcode;
    assign r1            = r_r1;
    assign r2            = r_r2;
    assign r3            = r_r3;
    assign imm           = r_imm;
    assign is_load       = r_is_load;
    assign is_store      = r_is_store;
    assign is_mem_access = r_is_load | r_is_store;
    assign is_branch     = r_is_branch;
    assign is_jump       = r_is_jump;
    assign stall_cnt     = r_stall_cnt;

endmodule
`default_nettype wire
